// File: rtl/muldiv_pkg.sv
// Shared definitions for the mul/div sequencer: command codes, FSM states, constants.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package muldiv_pkg;

   // Command codes decoded by EX and presented on op
   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_e;

   localparam int MD_DATA_W = 32;

   // Quotient reported for a zero divisor (no trap is raised)
   localparam logic [MD_DATA_W-1:0] DIV0_LO = '1;

   // True for the four iterative commands
   function automatic logic is_muldiv(input logic [2:0] op);
      return (op <= OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl_if.sv
// EX-side command/result bundle for the mul/div sequencer.
// Latency: n/a (wires only).
// Backpressure: EX must hold off new mul/div and MFHI/MFLO while busy is high.
interface muldiv_hilo_ctrl_if #(parameter int DATA_W = 32);
   logic              start;
   logic [2:0]        op;
   logic [DATA_W-1:0] Rdata1;
   logic [DATA_W-1:0] Rdata2;
   logic              flush;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] HI;
   logic [DATA_W-1:0] LO;

   // EX pipeline side
   modport master (
      output start, op, Rdata1, Rdata2, flush,
      input  busy, done, HI, LO
   );

   // Sequencer side
   modport slave (
      input  start, op, Rdata1, Rdata2, flush,
      output busy, done, HI, LO
   );
endinterface

// File: rtl/muldiv_iter_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// Latency: combinational.
// Backpressure: none; the controller decides when the result is captured.
module muldiv_iter_step #(
   parameter int DATA_W = 32
) (
   input  logic                  is_div,
   input  logic [2*DATA_W-1:0]   pr_in,    // {upper, lower} partial product / remainder
   input  logic [DATA_W-1:0]     operand,  // multiplicand or divisor magnitude
   output logic [2*DATA_W-1:0]   pr_out
);

   logic [DATA_W:0] mul_sum;
   logic [DATA_W:0] div_top;
   logic [DATA_W:0] div_diff;

   // Multiply consumes the multiplier LSB and shifts right; divide shifts left
   // and keeps the trial difference when it does not borrow.
   always_comb begin
      mul_sum  = {1'b0, pr_in[2*DATA_W-1:DATA_W]} + (pr_in[0] ? {1'b0, operand} : '0);
      // Remainder after the left shift, including the next dividend bit
      div_top  = pr_in[2*DATA_W-1:DATA_W-1];
      div_diff = div_top - {1'b0, operand};
      if (is_div) begin
         if (!div_diff[DATA_W]) begin
            pr_out = {div_diff[DATA_W-1:0], pr_in[DATA_W-2:0], 1'b1};
         end else begin
            pr_out = {div_top[DATA_W-1:0], pr_in[DATA_W-2:0], 1'b0};
         end
      end else begin
         pr_out = {mul_sum, pr_in[DATA_W-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// Mul/div sequencer owning HI/LO; accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX.
// Latency: mul/div writes HI/LO DATA_W+1 edges after start, done pulses the cycle after; MTHI/MTLO in one edge.
// Backpressure: busy is high while iterating; commands seen while busy are dropped, flush aborts.
module muldiv_hilo_ctrl
   import muldiv_pkg::*;
#(
   parameter int DATA_W = MD_DATA_W
) (
   input  logic               CLK,
   input  logic               RST,
   muldiv_hilo_ctrl_if.slave  bus
);

   localparam int CW = $clog2(DATA_W);

   state_e              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [2*DATA_W-1:0] pr_q, pr_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic                is_div_q, is_div_d;
   logic                neg_lo_q, neg_lo_d;   // product / quotient sign
   logic                neg_hi_q, neg_hi_d;   // remainder sign (dividend's)
   logic                div0_q, div0_d;
   logic [DATA_W-1:0]   hi_q, hi_d;
   logic [DATA_W-1:0]   lo_q, lo_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [2*DATA_W-1:0] step_pr;
   logic                op_signed;
   logic                op_div;
   logic                a_neg;
   logic                b_neg;
   logic [DATA_W-1:0]   a_mag;
   logic [DATA_W-1:0]   b_mag;
   logic [2*DATA_W-1:0] prod_fix;
   logic [DATA_W-1:0]   quo_fix;
   logic [DATA_W-1:0]   rem_fix;

   muldiv_iter_step #(.DATA_W(DATA_W)) u_step (
      .is_div  (is_div_q),
      .pr_in   (pr_q),
      .operand (b_q),
      .pr_out  (step_pr)
   );

   // Next-state, operand capture, iteration and HI/LO write-back
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pr_d     = pr_q;
      b_d      = b_q;
      is_div_d = is_div_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      div0_d   = div0_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;

      op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
      op_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
      a_neg     = op_signed & bus.Rdata1[DATA_W-1];
      b_neg     = op_signed & bus.Rdata2[DATA_W-1];
      a_mag     = a_neg ? -bus.Rdata1 : bus.Rdata1;
      b_mag     = b_neg ? -bus.Rdata2 : bus.Rdata2;

      prod_fix  = neg_lo_q ? -pr_q : pr_q;
      quo_fix   = neg_lo_q ? -pr_q[DATA_W-1:0] : pr_q[DATA_W-1:0];
      rem_fix   = neg_hi_q ? -pr_q[2*DATA_W-1:DATA_W] : pr_q[2*DATA_W-1:DATA_W];

      unique case (state_q)
         IDLE: begin
            // flush beats a same-cycle command of any kind
            if (bus.start && !bus.flush) begin
               if (is_muldiv(bus.op)) begin
                  pr_d     = {{DATA_W{1'b0}}, a_mag};
                  b_d      = b_mag;
                  is_div_d = op_div;
                  neg_lo_d = a_neg ^ b_neg;
                  neg_hi_d = op_div ? a_neg : (a_neg ^ b_neg);
                  div0_d   = op_div && (bus.Rdata2 == '0);
                  cnt_d    = CW'(DATA_W - 1);
                  state_d  = RUN;
               end else if (bus.op == OP_MTHI) begin
                  hi_d = bus.Rdata1;
               end else if (bus.op == OP_MTLO) begin
                  lo_d = bus.Rdata1;
               end
            end
         end
         RUN: begin
            if (bus.flush) begin
               state_d = IDLE;
            end else begin
               pr_d = step_pr;
               if (cnt_q == '0) begin
                  state_d = FIN;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         FIN: begin
            state_d = IDLE;
            if (!bus.flush) begin
               if (is_div_q) begin
                  hi_d = rem_fix;
                  lo_d = div0_q ? {DATA_W{DIV0_LO[0]}} : quo_fix;
               end else begin
                  {hi_d, lo_d} = prod_fix;
               end
               done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and datapath registers; reset takes effect immediately
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         pr_q     <= '0;
         b_q      <= '0;
         is_div_q <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         div0_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pr_q     <= pr_d;
         b_q      <= b_d;
         is_div_q <= is_div_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         div0_q   <= div0_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.HI   = hi_q;
   assign bus.LO   = lo_q;

endmodule

// File: doc/muldiv_hilo_ctrl.md
Name: muldiv_hilo_ctrl

Overview:
Multi-cycle multiply/divide sequencer and owner of the architectural HI/LO registers, sitting beside the EX stage ALU. It accepts MULT/MULTU/DIV/DIVU and MTHI/MTLO commands from EX, iterates one bit per cycle, and raises busy so the pipeline stalls any MFHI/MFLO or new mul/div. HI/LO are exposed continuously for MFHI/MFLO reads.

Parameters:
DATA_W, 32, operand/HI/LO width; iteration count equals DATA_W

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-high
start  input  1  command valid this cycle (from EX decode)
op  input  3  command code (package constants)
Rdata1  input  DATA_W  rs operand: multiplicand / dividend / MTHI-MTLO source
Rdata2  input  DATA_W  rt operand: multiplier / divisor
flush  input  1  synchronous abort (branch/exception squash)
busy  output  1  registered; high while an iterative op is in progress
done  output  1  registered one-cycle pulse: HI/LO just updated by mul/div
HI  output  DATA_W  HI register
LO  output  DATA_W  LO register

Behaviour:
- Clock CLK; reset RST is asynchronous and active-high. On RST: state IDLE, HI=0, LO=0, busy=0, done=0, counter=0; applies immediately, including mid-operation.
- States: IDLE, RUN, FIN. busy = (state != IDLE), registered.
- IDLE, start=1, op in {MULT,MULTU,DIV,DIVU}: latch magnitudes (signed ops: absolute values; record result signs), counter=DATA_W-1, go RUN.
- IDLE, start=1, op=MTHI: HI<=Rdata1 at that edge; op=MTLO: LO<=Rdata1. No busy, no done.
- RUN: one iteration per edge (multiply: shift-add; divide: restoring shift-subtract on 2*DATA_W partial remainder). Counter decrements; at counter=0 the iteration completes and the state goes to FIN.
- FIN: apply sign correction and write HI/LO. Multiply: {HI,LO}=product. Divide: LO=quotient, HI=remainder; the remainder takes the dividend's sign. Then go IDLE with done=1 for one cycle.
- Latency: start sampled at edge 0; DATA_W iteration edges (1..32); HI/LO written at edge 33. busy is high after edge 0 through edge 33 and low after edge 33. done is high for the cycle after edge 33.
- Divide by zero: no trap, normal latency, HI=Rdata1 (dividend unchanged), LO=all ones.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- start while busy: ignored entirely, including MTHI/MTLO. The pipeline is responsible for stalling on busy.
- op not in the six defined codes: ignored.
- flush=1: the next edge forces IDLE and clears busy. HI/LO keep their pre-command values and no done is generated. flush and start in the same cycle: flush wins.
- HI/LO change only at a FIN write, MTHI/MTLO, or reset.

Decomposition:
- Package muldiv_pkg holds:
  - op codes: OP_MULT=3'd0, OP_MULTU=3'd1, OP_DIV=3'd2, OP_DIVU=3'd3, OP_MTHI=3'd4, OP_MTLO=3'd5;
  - state encoding IDLE/RUN/FIN;
  - DIV0_LO constant (all ones).
- One sub-module, muldiv_iter_step: combinational single-bit step (add-shift or subtract-shift) selected by an is_div flag; width DATA_W.
- The controller owns the FSM, counter, sign handling and HI/LO.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; done one cycle after edge 33; busy low exactly then.
- MULT 0xFFFFFFFD(-3) x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIVU 7/2 -> LO=3, HI=1.
- DIV 0xFFFFFFF9(-7)/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x1234/0 -> HI=0x1234, LO=0xFFFFFFFF after the normal 33-edge latency; done pulses.
- MTHI 0xA5A5A5A5, then MULTU, then start of DIVU at cycle 5 (ignored), then flush at cycle 10 -> busy low next cycle, HI=0xA5A5A5A5, LO unchanged, no done.
- RST asserted asynchronously mid-RUN at cycle 15 -> HI=0, LO=0, busy=0 immediately. A fresh MULTU 6x7 afterwards -> LO=42, HI=0.
